// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen_if
// Function : request/stream bundle between a pattern source client and
//            seq_pattern_gen.
// Revision : 1.0
// ============================================================================
interface seq_pattern_gen_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 8
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   reps;
  logic               out;
  logic               out_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern, len, reps,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output out, out_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Function : serial MSB-first pattern transmitter with repeat count; defining
//            SEQ_GEN_PARITY_EN adds an even-parity bit after each repetition.
// Revision : 1.0
// ============================================================================
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 8
) (
  input  wire              clk,
  input  wire              rst_n,
  seq_pattern_gen_if.slave bus
);

  localparam int              IDX_W     = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef SEQ_GEN_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SEQ_GEN_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [LEN_W-1:0]   w_eff_len;
  logic [MAX_LEN-1:0] w_pat_src;
  logic [IDX_W-1:0]   w_bit_sel;

  assign w_eff_len = (bus.len > C_MAX_LEN) ? C_MAX_LEN : bus.len;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    w_pat_src = pat_q;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          state_d   = S_SHIFT;
          pat_d     = bus.pattern;
          len_d     = w_eff_len;
          idx_d     = w_eff_len - LEN_W'(1);
          // rep_q counts repetitions still owed after the current one
          rep_d     = (bus.reps == '0) ? '0 : bus.reps - REP_W'(1);
          w_pat_src = bus.pattern;
`ifdef SEQ_GEN_PARITY_EN
          par_d     = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
        par_d = par_q ^ out_q;
`endif
        if (idx_q != '0) begin
          idx_d = idx_q - LEN_W'(1);
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PARITY;
`else
          if (rep_q != '0) begin
            idx_d = len_q - LEN_W'(1);
            rep_d = rep_q - REP_W'(1);
          end else begin
            state_d = S_DONE;
          end
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        if (rep_q != '0) begin
          state_d = S_SHIFT;
          idx_d   = len_q - LEN_W'(1);
          rep_d   = rep_q - REP_W'(1);
          par_d   = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed for the state being entered so they leave on flops
    w_bit_sel = idx_d[IDX_W-1:0];
    case (state_d)
      S_SHIFT: begin
        out_d   = w_pat_src[w_bit_sel];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        out_d   = par_d;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire
